vc_tx_arbiter: RTL and testbench

- Downstream stage of the two virtual-channel FIFOs (VC0, VC1) on the transmit path.
- Pops words from VC0/VC1 with strict VC0 priority plus a starvation guard for VC1.
- Forwards each popped word, registered, to the next-stage FIFO.
- Throttles popping on next-stage almost-full; flags when the path is fully drained.

---
 rtl/vc_tx_arbiter_if.sv | 33 +++
 rtl/vc_tx_arbiter.sv | 110 +++++++++++
 tb/tb_vc_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_tx_arbiter_if.sv
// Handshake bundle between the VC0/VC1 FIFO read side, the arbiter and the next-stage FIFO write side.
// master = arbiter view; slave = environment view (FIFOs plus next stage).
interface vc_tx_arbiter_if #(
    parameter int data_width = 6
);
    logic                  empty_fifo_VC0;
    logic                  empty_fifo_VC1;
    logic [data_width-1:0] data_out_VC0;
    logic [data_width-1:0] data_out_VC1;
    logic                  almost_full_next;
    logic                  pop_VC0;
    logic                  pop_VC1;
    logic                  push_next;
    logic [data_width-1:0] data_next;
    logic                  vc_sel;
    logic                  idle;

    modport master (
        input  empty_fifo_VC0, empty_fifo_VC1,
        input  data_out_VC0, data_out_VC1,
        input  almost_full_next,
        output pop_VC0, pop_VC1,
        output push_next, data_next, vc_sel, idle
    );

    modport slave (
        output empty_fifo_VC0, empty_fifo_VC1,
        output data_out_VC0, data_out_VC1,
        output almost_full_next,
        input  pop_VC0, pop_VC1,
        input  push_next, data_next, vc_sel, idle
    );
endinterface

// File: rtl/vc_tx_arbiter.sv
// VC0-priority pop arbiter with VC1 starvation guard; pop->push latency 2 cycles.
// almost_full_next blocks new pops in the same cycle; up to 2 already-popped words still drain.
module vc_tx_arbiter #(
    parameter int data_width = 6,
    parameter int MAX_CONSEC = 4
) (
    input  logic           clk,
    input  logic           reset,
    vc_tx_arbiter_if.master bus
);
    localparam logic [2:0] MAX_CNT = 3'(MAX_CONSEC);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [2:0]            consec_cnt;
    logic                  inflight;
    logic                  inflight_vc;
    logic                  push_q;
    logic [data_width-1:0] data_q;
    logic                  vc_sel_q;
    logic                  grant_vc0;
    logic                  grant_vc1;
    logic                  pop_any;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE:   if (pop_any) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!pop_any && !inflight) state_d = ST_IDLE;
            default:   state_d = ST_INIT;
        endcase
    end

    // Output logic: guard overrides VC0 priority once VC0 has won MAX_CONSEC times in a row
    always_comb begin
        grant_vc0 = 1'b0;
        grant_vc1 = 1'b0;
        if (state_q != ST_INIT && !bus.almost_full_next) begin
            if (consec_cnt == MAX_CNT && !bus.empty_fifo_VC1) begin
                grant_vc1 = 1'b1;
            end else if (!bus.empty_fifo_VC0) begin
                grant_vc0 = 1'b1;
            end else if (!bus.empty_fifo_VC1) begin
                grant_vc1 = 1'b1;
            end
        end
        pop_any = grant_vc0 | grant_vc1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            consec_cnt <= 3'd0;
        end else if (grant_vc1) begin
            consec_cnt <= 3'd0;
        end else if (grant_vc0 && consec_cnt != MAX_CNT) begin
            consec_cnt <= consec_cnt + 3'd1;
        end
    end

    // Stage 1 remembers which FIFO was popped; its data shows up one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight    <= 1'b0;
            inflight_vc <= 1'b0;
        end else begin
            inflight    <= pop_any;
            inflight_vc <= grant_vc1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_q   <= 1'b0;
            data_q   <= '0;
            vc_sel_q <= 1'b0;
        end else if (inflight) begin
            push_q   <= 1'b1;
            data_q   <= inflight_vc ? bus.data_out_VC1 : bus.data_out_VC0;
            vc_sel_q <= inflight_vc;
        end else begin
            push_q   <= 1'b0;
            data_q   <= '0;
        end
    end

    assign bus.pop_VC0   = grant_vc0;
    assign bus.pop_VC1   = grant_vc1;
    assign bus.push_next = push_q;
    assign bus.data_next = data_q;
    assign bus.vc_sel    = vc_sel_q;
    assign bus.idle      = !pop_any && !inflight && !push_q;

endmodule

// File: tb/tb_vc_tx_arbiter.sv
// Directed bench for vc_tx_arbiter with behavioural VC0/VC1 FIFOs (read data valid the cycle after pop).
module tb_vc_tx_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    vc_tx_arbiter_if #(.data_width(6)) bus ();

    vc_tx_arbiter #(.data_width(6), .MAX_CONSEC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [5:0] mem0 [64];
    logic [5:0] mem1 [64];
    int         wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
    logic [5:0] d0 = 6'h00, d1 = 6'h00;

    assign bus.empty_fifo_VC0 = (rd0 == wr0);
    assign bus.empty_fifo_VC1 = (rd1 == wr1);
    assign bus.data_out_VC0   = d0;
    assign bus.data_out_VC1   = d1;

    always @(posedge clk) begin
        if (bus.pop_VC0 && rd0 != wr0) begin
            d0  <= mem0[rd0];
            rd0 <= rd0 + 1;
        end
        if (bus.pop_VC1 && rd1 != wr1) begin
            d1  <= mem1[rd1];
            rd1 <= rd1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.pop_VC0) begin
            chk("pop0_nonempty", 32'(bus.empty_fifo_VC0), 32'd0);
            chk("pop_onehot", 32'(bus.pop_VC1), 32'd0);
        end
        if (bus.pop_VC1) chk("pop1_nonempty", 32'(bus.empty_fifo_VC1), 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load0(input logic [5:0] w);
        mem0[wr0] = w;
        wr0++;
    endtask

    task automatic load1(input logic [5:0] w);
        mem1[wr1] = w;
        wr1++;
    endtask

    task automatic chk_push(input string tag, input logic p, input logic [5:0] d, input logic v);
        chk({tag, "_push"}, 32'(bus.push_next), 32'(p));
        chk({tag, "_data"}, 32'(bus.data_next), 32'(d));
        if (p) chk({tag, "_vcsel"}, 32'(bus.vc_sel), 32'(v));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20 && !bus.idle; i++) tick();
        chk(tag, 32'(bus.idle), 32'd1);
    endtask

    logic       seq [12];
    logic [5:0] expq [$];
    logic [5:0] e;
    int         n0, n1;

    initial begin
        bus.almost_full_next = 1'b0;
        seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset with both FIFOs non-empty
        load0(6'h15);
        load1(6'h2A);
        #1;
        chk("rst_pop0", 32'(bus.pop_VC0), 32'd0);
        chk("rst_pop1", 32'(bus.pop_VC1), 32'd0);
        chk("rst_idle", 32'(bus.idle), 32'd1);
        chk_push("rst", 1'b0, 6'h00, 1'b0);
        chk("rst_vcsel", 32'(bus.vc_sel), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_pop0", 32'(bus.pop_VC0), 32'd0);
        end
        reset = 1'b1;
        #1;
        chk("init_pop0", 32'(bus.pop_VC0), 32'd0);
        chk("init_pop1", 32'(bus.pop_VC1), 32'd0);
        chk("init_idle", 32'(bus.idle), 32'd1);
        tick();
        chk("first_pop0", 32'(bus.pop_VC0), 32'd1);
        chk("first_idle", 32'(bus.idle), 32'd0);
        tick();
        chk("second_pop1", 32'(bus.pop_VC1), 32'd1);
        chk_push("second", 1'b0, 6'h00, 1'b0);
        tick();
        chk_push("first_word", 1'b1, 6'h15, 1'b0);
        tick();
        chk_push("second_word", 1'b1, 6'h2A, 1'b1);
        tick();
        chk_push("drained", 1'b0, 6'h00, 1'b0);
        chk("drained_idle", 32'(bus.idle), 32'd1);

        // Single VC0 word
        tick();
        load0(6'h15);
        #1;
        chk("single_pop0", 32'(bus.pop_VC0), 32'd1);
        tick();
        chk("single_t1_pop0", 32'(bus.pop_VC0), 32'd0);
        chk("single_t1_idle", 32'(bus.idle), 32'd0);
        tick();
        chk_push("single_t2", 1'b1, 6'h15, 1'b0);
        tick();
        chk_push("single_t3", 1'b0, 6'h00, 1'b0);
        chk("single_t3_idle", 32'(bus.idle), 32'd1);

        // VC1 only
        tick();
        load1(6'h01);
        load1(6'h02);
        load1(6'h03);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            #1;
            if (i < 3) begin
                chk("vc1_pop1", 32'(bus.pop_VC1), 32'd1);
                chk("vc1_pop0", 32'(bus.pop_VC0), 32'd0);
            end
            if (i >= 2) chk_push("vc1", 1'b1, 6'(i - 1), 1'b1);
        end
        tick();
        chk("vc1_idle", 32'(bus.idle), 32'd1);

        // Starvation guard: counter was cleared by the VC1 grants above
        tick();
        for (int k = 0; k < 10; k++) load0(6'h10 + 6'(k));
        load1(6'h30);
        load1(6'h31);
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) tick();
            #1;
            if (i < 12) begin
                chk("guard_pop1", 32'(bus.pop_VC1), 32'(seq[i]));
                chk("guard_pop0", 32'(bus.pop_VC0), 32'(!seq[i]));
                if (seq[i]) begin
                    expq.push_back(6'h30 + 6'(n1));
                    n1++;
                end else begin
                    expq.push_back(6'h10 + 6'(n0));
                    n0++;
                end
            end
            if (i >= 2) begin
                e = expq.pop_front();
                chk_push("guard", 1'b1, e, seq[i-2]);
            end
        end
        tick();
        chk("guard_idle", 32'(bus.idle), 32'd1);

        // Backpressure during continuous VC0 traffic
        tick();
        for (int k = 0; k < 8; k++) load0(6'h20 + 6'(k));
        #1;
        chk("bp_c0_pop0", 32'(bus.pop_VC0), 32'd1);
        tick();
        chk("bp_c1_pop0", 32'(bus.pop_VC0), 32'd1);
        tick();
        bus.almost_full_next = 1'b1;
        #1;
        chk("bp_t_pop0", 32'(bus.pop_VC0), 32'd0);
        chk_push("bp_t", 1'b1, 6'h20, 1'b0);
        tick();
        chk("bp_t1_pop0", 32'(bus.pop_VC0), 32'd0);
        chk_push("bp_t1", 1'b1, 6'h21, 1'b0);
        tick();
        chk("bp_t2_pop0", 32'(bus.pop_VC0), 32'd0);
        chk_push("bp_t2", 1'b0, 6'h00, 1'b0);
        tick();
        bus.almost_full_next = 1'b0;
        #1;
        chk("bp_resume_pop0", 32'(bus.pop_VC0), 32'd1);
        tick();
        tick();
        chk_push("bp_resume", 1'b1, 6'h22, 1'b0);
        wait_idle("bp_drain_idle");

        // Reset asserted one cycle after a pop
        tick();
        load0(6'h3C);
        load0(6'h3D);
        #1;
        chk("mid_pop0", 32'(bus.pop_VC0), 32'd1);
        tick();
        chk("mid_t1_pop0", 32'(bus.pop_VC0), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_pop0", 32'(bus.pop_VC0), 32'd0);
        chk("mid_rst_idle", 32'(bus.idle), 32'd1);
        chk_push("mid_rst", 1'b0, 6'h00, 1'b0);
        tick();
        chk_push("mid_rst_hold", 1'b0, 6'h00, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_init_pop0", 32'(bus.pop_VC0), 32'd0);
        tick();
        chk("mid_repop0", 32'(bus.pop_VC0), 32'd1);
        chk_push("mid_repop", 1'b0, 6'h00, 1'b0);
        tick();
        chk_push("mid_gap", 1'b0, 6'h00, 1'b0);
        tick();
        chk_push("mid_survivor", 1'b1, 6'h3D, 1'b0);
        reset = 1'b0;
        #1;
        chk_push("mid_async_clear", 1'b0, 6'h00, 1'b0);
        tick();
        reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
